ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB-Lite SRAM slave with a programmable number of wait states. Sits directly upstream of the interconnect response mux: its h_readyout, h_resp and h_rdata drive one h_ready_x/h_resp_x/h_rdata_x slot. It receives the global h_ready back from that mux. Provides word-addressed storage with byte/halfword/word writes and a two-cycle ERROR response for illegal transfers.

Parameters:
DATA_WIDTH, 32, data bus width (32 only supported; width change needs lane-mask rework).
ADDR_WIDTH, 32, address bus width.
MEM_DEPTH, 256, number of DATA_WIDTH words; legal byte addresses are 0 .. MEM_DEPTH*4-1 (offset within slave region, upper bits ignored above log2(MEM_DEPTH)+2 only if zero).
WAIT_STATES, 1, wait cycles inserted in every OKAY data phase (0..15).

Ports:
h_clk  in  1  clock (single clock domain).
h_reset  in  1  synchronous active-high reset.
h_sel  in  1  slave select from decoder.
h_addr  in  ADDR_WIDTH  byte address (address phase).
h_trans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
h_write  in  1  1=write.
h_size  in  3  0=byte, 1=half, 2=word; >2 illegal.
h_wdata  in  DATA_WIDTH  write data (data phase).
h_ready  in  1  global ready from response mux.
h_readyout  out  1  this slave's ready to the mux.
h_resp  out  1  0=OKAY, 1=ERROR.
h_rdata  out  DATA_WIDTH  read data.

Behaviour:
- Reset (h_reset=1 at posedge): h_readyout=1, h_resp=0, h_rdata=0, FSM=IDLE, wait counter=0; memory contents not cleared. Reset mid-transfer abandons it; a pending write is not committed.
- Address phase accepted on posedge when h_sel & h_ready & h_trans[1]; captures addr, write, size. IDLE/BUSY or h_sel=0 -> OKAY zero-wait (h_readyout=1, h_resp=0).
- Illegal transfer: size>2, addr misaligned to size, or word index >= MEM_DEPTH / nonzero upper bits.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  IDLE: accepted legal -> WAIT if WAIT_STATES>0 else DATA; accepted illegal -> ERR1.
  WAIT: h_readyout=0, h_resp=0; counter counts WAIT_STATES cycles, then -> DATA.
  DATA: h_readyout=1, h_resp=0; read data valid on h_rdata; write commits at this posedge using h_wdata and byte mask. Same-edge new accept -> WAIT/DATA/ERR1 as from IDLE, else IDLE.
  ERR1: h_readyout=0, h_resp=1. -> ERR2.
  ERR2: h_readyout=1, h_resp=1; no memory access; pipelined accept allowed as in DATA.
- Latency: WAIT_STATES=0 gives one data-phase cycle per transfer, back-to-back at full throughput.
- Byte mask: byte lane = addr[1:0]; half lanes = addr[1]*2 +: 2; word = all four. Little-endian.
- h_rdata holds last read value outside read DATA cycles; error cycles drive 0.
- Read-after-write hazard: read whose address is accepted on the same edge a write commits to the same word must return the merged new data (forwarding).
- No accept while h_readyout=0 (h_ready low from this slave).

Optional Feature:
AHB_SRAM_STATS_EN: adds outputs rd_count[15:0], wr_count[15:0], err_count[15:0], counting completed OKAY reads, OKAY writes, and ERROR responses. Counters saturate at 16'hFFFF and reset to 0. Without the macro, the ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Package ahb_pkg: htrans_t enum, hsize_t enum, RESP_OKAY/RESP_ERROR constants, sram_state_t FSM enum.
- Sub-module ahb_byte_mask: combinational (size, addr[1:0]) -> 4-bit lane mask + alignment-legal flag.

Test Plan:
- WAIT_STATES=1: write word 0xDEADBEEF @0x10, read @0x10 -> one low-ready cycle each, h_rdata=0xDEADBEEF, h_resp=0.
- Byte write 0xAA @0x11 over 0x00000000, read word @0x10 -> 0x0000AA00; half write 0x1234 @0x12 -> 0x1234AA00.
- WAIT_STATES=0: write @0x20 with data 0x55, immediately followed by pipelined read @0x20 -> forwarding gives h_rdata=0x55, zero wait.
- Read @0x400 (MEM_DEPTH=256) -> ERR1 (ready=0,resp=1) then ERR2 (ready=1,resp=1); a pipelined read @0x0 in ERR2 completes OKAY.
- Half write @0x01 (misaligned) and h_size=3 -> both ERROR, memory unchanged.
- h_reset asserted during WAIT of a write @0x30 -> next cycle ready=1, resp=0, rdata=0; read @0x30 returns old value; with STATS_EN, counters=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, response codes and SRAM slave FSM encoding.
// Also holds small data-path helpers shared by the slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } sram_state_t;

  // Replace the byte lanes selected by mask in old_word with those of new_word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
    logic [15:0] res;
    if (en && (value != 16'hFFFF)) begin
      res = value + 16'd1;
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/ahb_byte_mask.sv
// Decodes transfer size and low address bits into a little-endian byte-lane
// mask plus a flag telling whether the size is supported and naturally aligned.
module ahb_byte_mask
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       aligned
);

  // Lane select and alignment check per supported size; larger sizes are illegal.
  always_comb begin
    mask    = 4'b0000;
    aligned = 1'b0;
    case (size)
      HSIZE_BYTE: begin
        mask    = 4'b0001 << addr_lo;
        aligned = 1'b1;
      end
      HSIZE_HALF: begin
        mask    = addr_lo[1] ? 4'b1100 : 4'b0011;
        aligned = ~addr_lo[0];
      end
      HSIZE_WORD: begin
        mask    = 4'b1111;
        aligned = (addr_lo == 2'b00);
      end
      default: begin
        mask    = 4'b0000;
        aligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with WAIT_STATES wait cycles per OKAY transfer and a
// two-cycle ERROR response. Optional counters enabled by AHB_SRAM_STATS_EN.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  h_clk,
  input  logic                  h_reset,
  input  logic                  h_sel,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [1:0]            h_trans,
  input  logic                  h_write,
  input  logic [2:0]            h_size,
  input  logic [DATA_WIDTH-1:0] h_wdata,
  input  logic                  h_ready,
  output logic                  h_readyout,
  output logic                  h_resp,
  output logic [DATA_WIDTH-1:0] h_rdata
`ifdef AHB_SRAM_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count,
  output logic [15:0]           err_count
`endif
);

  localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  sram_state_t           state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [3:0]            mask_q, mask_d;
  logic                  readyout_q, readyout_d;
  logic                  resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  trans_active;
  logic                  accept;
  logic                  in_range;
  logic                  aligned;
  logic                  legal;
  logic                  mem_we;
  logic                  fwd_hit;
  logic [3:0]            new_mask;
  logic [IDX_W-1:0]      new_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  ahb_byte_mask u_byte_mask (
    .size    (h_size),
    .addr_lo (h_addr[1:0]),
    .mask    (new_mask),
    .aligned (aligned)
  );

  assign trans_active = (h_trans == HTRANS_NONSEQ) || (h_trans == HTRANS_SEQ);
  assign accept       = h_sel && h_ready && trans_active &&
                        ((state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2));
  assign in_range     = ((h_addr >> 2) < ADDR_WIDTH'(MEM_DEPTH));
  assign legal        = aligned && in_range;
  assign new_idx      = h_addr[IDX_W+1:2];

  // A read loaded on the edge a write commits to the same word sees the merged data.
  assign rd_idx  = (state_q == ST_WAIT) ? idx_q : new_idx;
  assign fwd_hit = (state_q == ST_DATA) && write_q && (idx_q == rd_idx);
  assign rd_word = fwd_hit ? lane_merge(mem_q[rd_idx], h_wdata, mask_q) : mem_q[rd_idx];

  // Next-state, transfer capture and read-data load.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    mask_d     = mask_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        mem_we = (state_q == ST_DATA) && write_q;
        if (accept) begin
          idx_d   = new_idx;
          write_d = h_write;
          mask_d  = new_mask;
          if (!legal) begin
            state_d    = ST_ERR1;
            wait_cnt_d = 4'd0;
            rdata_d    = '0;
          end else if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d    = ST_DATA;
            wait_cnt_d = 4'd0;
            rdata_d    = h_write ? rdata_q : rd_word;
          end
        end else begin
          state_d    = ST_IDLE;
          wait_cnt_d = 4'd0;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_DATA;
          rdata_d = write_q ? rdata_q : rd_word;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
        rdata_d = '0;
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
    readyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    resp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
  end

  // Control and response registers.
  always_ff @(posedge h_clk) begin
    if (h_reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      mask_q     <= 4'b0000;
      readyout_q <= 1'b1;
      resp_q     <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      mask_q     <= mask_d;
      readyout_q <= readyout_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage is never cleared; a write caught by reset is dropped.
  always_ff @(posedge h_clk) begin
    if (!h_reset && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= h_wdata[8*b +: 8];
        end
      end
    end
  end

  assign h_readyout = readyout_q;
  assign h_resp     = resp_q;
  assign h_rdata    = rdata_q;

`ifdef AHB_SRAM_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Each completed transfer bumps exactly one saturating counter.
  always_comb begin
    rd_cnt_d  = sat_inc(rd_cnt_q, (state_q == ST_DATA) && !write_q);
    wr_cnt_d  = sat_inc(wr_cnt_q, mem_we);
    err_cnt_d = sat_inc(err_cnt_q, state_q == ST_ERR2);
  end

  // Statistics registers.
  always_ff @(posedge h_clk) begin
    if (h_reset) begin
      rd_cnt_q  <= 16'd0;
      wr_cnt_q  <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomized self-checking bench: two slaves (1 and 0 wait states), a byte-array
// memory model and a per-cycle queue of expected ready/resp/rdata values.
module tb_ahb_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        sel    [2];
  logic [31:0] addr   [2];
  logic [1:0]  trans  [2];
  logic        wr     [2];
  logic [2:0]  size   [2];
  logic [31:0] wdata  [2];
  logic        rdyin  [2];
  logic        rdyout [2];
  logic        resp   [2];
  logic [31:0] rdata  [2];
`ifdef AHB_SRAM_STATS_EN
  logic [15:0] rdc [2];
  logic [15:0] wrc [2];
  logic [15:0] erc [2];
`endif

  // Single-slave system: the global ready is this slave's own ready.
  assign rdyin[0] = rdyout[0];
  assign rdyin[1] = rdyout[1];

  ahb_sram_slave #(.WAIT_STATES(1)) u_ws1 (
    .h_clk(clk), .h_reset(rst[0]), .h_sel(sel[0]), .h_addr(addr[0]), .h_trans(trans[0]),
    .h_write(wr[0]), .h_size(size[0]), .h_wdata(wdata[0]), .h_ready(rdyin[0]),
    .h_readyout(rdyout[0]), .h_resp(resp[0]), .h_rdata(rdata[0])
`ifdef AHB_SRAM_STATS_EN
    , .rd_count(rdc[0]), .wr_count(wrc[0]), .err_count(erc[0])
`endif
  );

  ahb_sram_slave #(.WAIT_STATES(0)) u_ws0 (
    .h_clk(clk), .h_reset(rst[1]), .h_sel(sel[1]), .h_addr(addr[1]), .h_trans(trans[1]),
    .h_write(wr[1]), .h_size(size[1]), .h_wdata(wdata[1]), .h_ready(rdyin[1]),
    .h_readyout(rdyout[1]), .h_resp(resp[1]), .h_rdata(rdata[1])
`ifdef AHB_SRAM_STATS_EN
    , .rd_count(rdc[1]), .wr_count(wrc[1]), .err_count(erc[1])
`endif
  );

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic        chk_rd;
    logic [31:0] rd;
    logic        is_wr;
    logic [31:0] wd;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  mem_m [2][1024];
  int          cur = 0;
  int          checks = 0;
  int          errors = 0;
  logic        last_rdy = 1'b1;
  logic [31:0] got_rd;
  int          n_rd = 0;
  int          n_wr = 0;
  int          n_err = 0;

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic bit legal_m(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b0;
    if ((a & ((32'd1 << s) - 32'd1)) != 32'd0) return 1'b0;
    return a < 32'd1024;
  endfunction

  function automatic logic [31:0] word_m(input int d, input logic [31:0] a);
    int b;
    b = int'(a[9:2]) * 4;
    return {mem_m[d][b+3], mem_m[d][b+2], mem_m[d][b+1], mem_m[d][b]};
  endfunction

  task automatic write_m(input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    for (int i = 0; i < (1 << s); i++) begin
      int ba;
      ba = int'(a[9:0]) + i;
      mem_m[cur][ba] = wd[8*(ba % 4) +: 8];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s (dut%0d t=%0t): got %h expected %h", name, cur, $time, act, exp_v);
    end
  endtask

  // One clock: compare this cycle's outputs with the model, then set its write data.
  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
    end else begin
      e.rdy = 1'b1; e.rsp = 1'b0; e.chk_rd = 1'b0; e.rd = 32'd0; e.is_wr = 1'b0; e.wd = 32'd0;
    end
    chk("h_readyout", {31'd0, rdyout[cur]}, {31'd0, e.rdy});
    chk("h_resp", {31'd0, resp[cur]}, {31'd0, e.rsp});
    if (e.chk_rd) chk("h_rdata", rdata[cur], e.rd);
    got_rd     = rdata[cur];
    wdata[cur] = e.is_wr ? e.wd : $urandom();
    last_rdy   = e.rdy;
  endtask

  // Drive a non-transfer; while ready is low anything goes since it must be ignored.
  task automatic drive_idle();
    addr[cur] = $urandom() % 32'd1100;
    wr[cur]   = 1'($urandom_range(0, 1));
    size[cur] = 3'($urandom_range(0, 3));
    if (!last_rdy) begin
      sel[cur]   = 1'($urandom_range(0, 1));
      trans[cur] = 2'($urandom_range(0, 3));
    end else if ($urandom_range(0, 1) == 0) begin
      sel[cur]   = 1'b0;
      trans[cur] = 2'($urandom_range(0, 3));
    end else begin
      sel[cur]   = 1'b1;
      trans[cur] = 2'($urandom_range(0, 1));
    end
  endtask

  task automatic push(input logic rdy, input logic rsp, input logic c, input logic [31:0] rd,
                      input logic w, input logic [31:0] wd);
    exp_t e;
    e.rdy = rdy; e.rsp = rsp; e.chk_rd = c; e.rd = rd; e.is_wr = w; e.wd = wd;
    expq.push_back(e);
  endtask

  task automatic do_xfer(input bit w, input logic [2:0] s, input logic [31:0] a,
                         input logic [31:0] wd, input bit commit);
    while (!last_rdy) begin
      drive_idle();
      tick_check();
    end
    sel[cur]   = 1'b1;
    trans[cur] = ($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3;
    addr[cur]  = a;
    wr[cur]    = w;
    size[cur]  = s;
    if (legal_m(a, s)) begin
      for (int i = 0; i < ws_of(cur); i++) push(1'b0, 1'b0, 1'b0, 32'd0, w, wd);
      if (w) begin
        if (commit) write_m(a, s, wd);
        n_wr++;
        push(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, wd);
      end else begin
        n_rd++;
        push(1'b1, 1'b0, 1'b1, word_m(cur, a), 1'b0, 32'd0);
      end
    end else begin
      n_err++;
      push(1'b0, 1'b1, 1'b1, 32'd0, w, wd);
      push(1'b1, 1'b1, 1'b1, 32'd0, w, wd);
    end
    tick_check();
  endtask

  task automatic drain();
    while (expq.size() > 0) begin
      drive_idle();
      tick_check();
    end
  endtask

  task automatic read_lit(input logic [31:0] a, input logic [31:0] lit, input string name);
    do_xfer(1'b0, 3'd2, a, 32'd0, 1'b1);
    drain();
    chk(name, got_rd, lit);
    chk({name, "_model"}, word_m(cur, a), lit);
  endtask

  task automatic reset_dut();
    expq.delete();
    rst[cur]   = 1'b1;
    sel[cur]   = 1'b0;
    trans[cur] = 2'd0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("reset_readyout", {31'd0, rdyout[cur]}, 32'd1);
    chk("reset_resp", {31'd0, resp[cur]}, 32'd0);
    chk("reset_rdata", rdata[cur], 32'd0);
`ifdef AHB_SRAM_STATS_EN
    chk("reset_rd_count", {16'd0, rdc[cur]}, 32'd0);
    chk("reset_wr_count", {16'd0, wrc[cur]}, 32'd0);
    chk("reset_err_count", {16'd0, erc[cur]}, 32'd0);
`endif
    rst[cur] = 1'b0;
    last_rdy = 1'b1;
    n_rd = 0; n_wr = 0; n_err = 0;
  endtask

  task automatic init_and_random(input int n);
    for (int w = 0; w < 256; w++) do_xfer(1'b1, 3'd2, 32'(w * 4), 32'd0, 1'b1);
    drain();
    for (int k = 0; k < n; k++) begin
      int          r;
      logic [31:0] a;
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        drive_idle();
        tick_check();
      end
      r = int'($urandom_range(0, 19));
      if (r == 0)      a = 32'h400 + ($urandom() % 32'd64);
      else if (r == 1) a = 32'h0001_0000 | ($urandom() % 32'd64);
      else if (r == 2) a = 32'h3FC + ($urandom() % 32'd4);
      else             a = $urandom() % 32'd64;
      do_xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), a, $urandom(), 1'b1);
    end
    drain();
`ifdef AHB_SRAM_STATS_EN
    chk("rd_count", {16'd0, rdc[cur]}, 32'(n_rd));
    chk("wr_count", {16'd0, wrc[cur]}, 32'(n_wr));
    chk("err_count", {16'd0, erc[cur]}, 32'(n_err));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; sel[d] = 1'b0; addr[d] = 32'd0; trans[d] = 2'd0;
      wr[d] = 1'b0; size[d] = 3'd0; wdata[d] = 32'd0;
    end

    // One wait state: directed cases first, then random traffic.
    cur = 0;
    reset_dut();
    for (int w = 0; w < 256; w++) do_xfer(1'b1, 3'd2, 32'(w * 4), 32'd0, 1'b1);
    do_xfer(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1);
    read_lit(32'h10, 32'hDEADBEEF, "word_rd");
    do_xfer(1'b1, 3'd2, 32'h10, 32'h0, 1'b1);
    do_xfer(1'b1, 3'd0, 32'h11, 32'h0000AA00, 1'b1);
    read_lit(32'h10, 32'h0000AA00, "byte_wr");
    do_xfer(1'b1, 3'd1, 32'h12, 32'h12340000, 1'b1);
    read_lit(32'h10, 32'h1234AA00, "half_wr");
    do_xfer(1'b0, 3'd2, 32'h400, 32'h0, 1'b1);
    read_lit(32'h0, 32'h0, "rd_after_err");
    do_xfer(1'b1, 3'd1, 32'h01, 32'hFFFFFFFF, 1'b1);
    do_xfer(1'b1, 3'd3, 32'h00, 32'hFFFFFFFF, 1'b1);
    read_lit(32'h0, 32'h0, "illegal_no_write");
    do_xfer(1'b1, 3'd2, 32'h30, 32'h0BADF00D, 1'b1);
    do_xfer(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, 1'b0);
    reset_dut();
    read_lit(32'h30, 32'h0BADF00D, "reset_drops_write");
    init_and_random(300);
    sel[0] = 1'b0; trans[0] = 2'd0;

    // Zero wait states: pipelined read-after-write forwarding, then random traffic.
    cur = 1;
    reset_dut();
    for (int w = 0; w < 256; w++) do_xfer(1'b1, 3'd2, 32'(w * 4), 32'd0, 1'b1);
    do_xfer(1'b1, 3'd2, 32'h20, 32'h00000055, 1'b1);
    read_lit(32'h20, 32'h00000055, "fwd_word");
    do_xfer(1'b1, 3'd0, 32'h21, 32'h0000AB00, 1'b1);
    read_lit(32'h20, 32'h0000AB55, "fwd_byte");
    init_and_random(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
